// File: rtl/lcd_video_receiver.sv
// rtl/lcd_video_receiver.sv - LCD parallel video receiver: x/y recovery, width/height measurement, lock FSM
// Optional feature macro: LCD_RX_STATS_EN adds frame_count/error_count outputs.
module lcd_video_receiver #(
  parameter int DATA_W      = 24,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              hs_n,
  input  logic              vs_n,
  input  logic              data_enable,
  input  logic [DATA_W-1:0] pixel_in,
  output logic              pixel_valid,
  output logic [DATA_W-1:0] pixel_out,
  output logic [10:0]       x,
  output logic [10:0]       y,
  output logic              frame_start,
  output logic [10:0]       width,
  output logic [10:0]       height,
  output logic              locked,
  output logic              sync_error
`ifdef LCD_RX_STATS_EN
  ,
  output logic [15:0]       frame_count,
  output logic [15:0]       error_count
`endif
);
  localparam logic [10:0] COORD_MAX = 11'h7FF;

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;
  state_t state;

  logic        de_q, vs_q, hs_unused;
  logic [10:0] xc, yc, ref_w, ref_h;
  logic [3:0]  cnt;
  logic        frame_bad;
  logic        de_fall, vs_fall, line_mis, frame_good, lock_loss;
  logic [10:0] yc_inc, lines_now, cur_w;
  logic [4:0]  cnt_next;

  // A line ending in the same tick as vs_fall is folded into the frame's line count and width.
  always_comb begin
    de_fall    = tick & ~data_enable & de_q;
    vs_fall    = tick & ~vs_n & vs_q;
    yc_inc     = (yc == COORD_MAX) ? yc : yc + 11'd1;
    lines_now  = de_fall ? yc_inc : yc;
    cur_w      = de_fall ? xc : width;
    line_mis   = de_fall && (xc != ref_w);
    frame_good = !frame_bad && !line_mis && !data_enable && (lines_now == ref_h);
    lock_loss  = (state == LOCKED) && (line_mis || (vs_fall && (lines_now != ref_h)));
    cnt_next   = {1'b0, cnt} + 5'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= HUNT;
      de_q        <= 1'b0;
      vs_q        <= 1'b1;
      hs_unused   <= 1'b1;
      xc          <= '0;
      yc          <= '0;
      ref_w       <= '0;
      ref_h       <= '0;
      cnt         <= '0;
      frame_bad   <= 1'b0;
      pixel_valid <= 1'b0;
      pixel_out   <= '0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      width       <= '0;
      height      <= '0;
      locked      <= 1'b0;
      sync_error  <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      sync_error  <= 1'b0;

      if (tick) begin
        de_q      <= data_enable;
        vs_q      <= vs_n;
        hs_unused <= hs_n;
      end

      if (tick && data_enable) begin
        pixel_valid <= 1'b1;
        pixel_out   <= pixel_in;
        x           <= xc;
        y           <= yc;
        if (xc != COORD_MAX) xc <= xc + 11'd1;
      end

      if (de_fall) begin
        width <= xc;
        xc    <= '0;
        yc    <= yc_inc;
        if (line_mis) frame_bad <= 1'b1;
      end

      // vs_fall wins over the line updates above; a line still active here is dropped.
      if (vs_fall) begin
        height      <= lines_now;
        xc          <= '0;
        yc          <= '0;
        frame_start <= 1'b1;
        frame_bad   <= 1'b0;
      end

      case (state)
        HUNT: begin
          if (vs_fall && (cur_w != '0) && (lines_now != '0)) begin
            ref_w <= cur_w;
            ref_h <= lines_now;
            cnt   <= '0;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (vs_fall) begin
            if (frame_good) begin
              cnt <= cnt_next[3:0];
              if (cnt_next == 5'(LOCK_FRAMES)) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              ref_w <= cur_w;
              ref_h <= lines_now;
              cnt   <= '0;
            end
          end
        end
        LOCKED: begin
          if (lock_loss) begin
            state      <= HUNT;
            locked     <= 1'b0;
            sync_error <= 1'b1;
          end
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef LCD_RX_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= '0;
      error_count <= '0;
    end else begin
      if (vs_fall) frame_count <= frame_count + 16'd1;
      if (lock_loss && (error_count != 16'hFFFF)) error_count <= error_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lcd_video_receiver.sv
// tb/tb_lcd_video_receiver.sv - self-checking bench for lcd_video_receiver on a scaled-down 20x12 stream
module tb_lcd_video_receiver;
  localparam int DW     = 24;
  localparam int ACT_W  = 20;
  localparam int LINE_T = 26;
  localparam int V_T    = 15;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          tick = 1'b0;
  logic          hs_n = 1'b1;
  logic          vs_n = 1'b1;
  logic          data_enable = 1'b0;
  logic [DW-1:0] pixel_in = '0;
  logic          pixel_valid;
  logic [DW-1:0] pixel_out;
  logic [10:0]   x, y, width, height;
  logic          frame_start, locked, sync_error;
`ifdef LCD_RX_STATS_EN
  logic [15:0]   frame_count, error_count;
`endif

  always #5 clock = ~clock;

  lcd_video_receiver #(.DATA_W(DW), .LOCK_FRAMES(2)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .tick        (tick),
    .hs_n        (hs_n),
    .vs_n        (vs_n),
    .data_enable (data_enable),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .pixel_out   (pixel_out),
    .x           (x),
    .y           (y),
    .frame_start (frame_start),
    .width       (width),
    .height      (height),
    .locked      (locked),
    .sync_error  (sync_error)
`ifdef LCD_RX_STATS_EN
    ,
    .frame_count (frame_count),
    .error_count (error_count)
`endif
  );

  typedef struct packed {
    logic [10:0]   px;
    logic [10:0]   py;
    logic [DW-1:0] pd;
  } pix_t;

  typedef struct {
    int n_act;
    int short_row;
    bit same;
    int ew;
    int eh;
    bit el;
    int eserr;
    int elx;
    int ely;
  } vec_t;

  vec_t tbl[16];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   pix_bad = 0;
  int   serr_cnt = 0;
  int   fs_cnt = 0;
  int   last_x = 0;
  int   last_y = 0;
  int   gap = 1000;
  int   min_gap = 1000;
  bit   div2 = 1'b0;
  bit   pix_chk = 1'b1;
  bit   pend_valid = 1'b0;
  pix_t pend = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Outputs seen at this negedge belong to the inputs driven one clock earlier (held in pend).
  task automatic observe();
    if (pixel_valid === 1'b1) begin
      last_x = int'(x);
      last_y = int'(y);
      if (div2 && gap < min_gap) min_gap = gap;
      gap = 1;
    end else if (gap < 1000) begin
      gap++;
    end
    if (pix_chk) begin
      if (pixel_valid !== pend_valid) pix_bad++;
      else if (pixel_valid === 1'b1 && {x, y, pixel_out} !== pend) pix_bad++;
    end
    if (sync_error === 1'b1) serr_cnt++;
    if (frame_start === 1'b1) fs_cnt++;
  endtask

  task automatic step(input bit t, input bit de, input bit hs, input bit vs,
                      input logic [DW-1:0] d, input int ex, input int ey);
    @(posedge clock);
    #1;
    tick        = t;
    data_enable = de;
    hs_n        = hs;
    vs_n        = vs;
    pixel_in    = d;
    @(negedge clock);
    observe();
    pend_valid = t && de;
    pend       = {11'(ex), 11'(ey), d};
  endtask

  task automatic check_zero(input string tag);
    check({tag, " pixel_valid"}, pixel_valid, 0);
    check({tag, " pixel_out"}, pixel_out, 0);
    check({tag, " x"}, x, 0);
    check({tag, " y"}, y, 0);
    check({tag, " frame_start"}, frame_start, 0);
    check({tag, " width"}, width, 0);
    check({tag, " height"}, height, 0);
    check({tag, " locked"}, locked, 0);
    check({tag, " sync_error"}, sync_error, 0);
`ifdef LCD_RX_STATS_EN
    check({tag, " frame_count"}, frame_count, 0);
    check({tag, " error_count"}, error_count, 0);
`endif
  endtask

  task automatic do_reset();
    pix_chk = 1'b0;
    @(posedge clock);
    #1;
    tick    = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    check_zero("midreset");
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Rows 0..n_act-1 carry pixels; vs_n low on the last two rows, or from the
  // last line's de_fall tick through the next row when 'same' is set.
  task automatic run_frame(input int n_act, input int short_row, input bit same, input int dv,
                           input int rst_row, input int rst_col);
    for (int r = 0; r < V_T; r++) begin
      for (int c = 0; c < LINE_T; c++) begin
        int            w;
        bit            de, hs, vs;
        logic [DW-1:0] d;
        w  = (r == short_row) ? ACT_W - 1 : ACT_W;
        de = (r < n_act) && (c < w);
        hs = !(c >= 22 && c < 24);
        if (same) vs = !((r == n_act - 1 && c >= w) || r == n_act);
        else      vs = !(r >= V_T - 2);
        if (r == rst_row && c == rst_col) do_reset();
        d = de ? DW'($urandom) : '0;
        for (int k = 0; k < dv; k++) step(k == 0, de, hs, vs, d, c, r);
      end
    end
  endtask

  task automatic frame_test(input string tag, input vec_t v, input int dv);
    int s0, f0, p0;
    s0 = serr_cnt;
    f0 = fs_cnt;
    p0 = pix_bad;
    pix_chk = 1'b1;
    run_frame(v.n_act, v.short_row, v.same, dv, -1, -1);
    check({tag, " width"}, width, v.ew);
    check({tag, " height"}, height, v.eh);
    check({tag, " locked"}, locked, v.el);
    check({tag, " sync_error pulses"}, serr_cnt - s0, v.eserr);
    check({tag, " frame_start pulses"}, fs_cnt - f0, 1);
    check({tag, " pixel stream errors"}, pix_bad - p0, 0);
    check({tag, " last x"}, last_x, v.elx);
    check({tag, " last y"}, last_y, v.ely);
  endtask

  initial begin
    int s0, p0;
    tbl[0]  = '{12, -1, 1'b0, 20, 12, 1'b0, 0, 19, 11};
    tbl[1]  = '{12, -1, 1'b0, 20, 12, 1'b0, 0, 19, 11};
    tbl[2]  = '{12, -1, 1'b0, 20, 12, 1'b1, 0, 19, 11};
    tbl[3]  = '{12, -1, 1'b0, 20, 12, 1'b1, 0, 19, 11};
    tbl[4]  = '{12,  5, 1'b0, 20, 12, 1'b0, 1, 19, 11};
    tbl[5]  = '{12, -1, 1'b0, 20, 12, 1'b0, 0, 19, 11};
    tbl[6]  = '{12, -1, 1'b0, 20, 12, 1'b1, 0, 19, 11};
    tbl[7]  = '{11, -1, 1'b0, 20, 11, 1'b0, 1, 19, 10};
    tbl[8]  = '{12, -1, 1'b0, 20, 12, 1'b0, 0, 19, 11};
    tbl[9]  = '{12, -1, 1'b0, 20, 12, 1'b0, 0, 19, 11};
    tbl[10] = '{12, -1, 1'b1, 20, 12, 1'b1, 0, 19, 11};
    tbl[11] = '{12, -1, 1'b1, 20, 12, 1'b1, 0, 19, 11};
    tbl[12] = '{12, 11, 1'b0, 19, 12, 1'b0, 1, 18, 11};
    tbl[13] = '{12, -1, 1'b0, 20, 12, 1'b0, 0, 19, 11};
    tbl[14] = '{12, -1, 1'b0, 20, 12, 1'b0, 0, 19, 11};
    tbl[15] = '{12, -1, 1'b0, 20, 12, 1'b1, 0, 19, 11};

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_zero("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) frame_test($sformatf("f%0d", i), tbl[i], 1);

    // Half-rate ticks: same geometry, pulses one clock wide and two clocks apart.
    div2 = 1'b1;
    frame_test("div2_a", tbl[3], 2);
    frame_test("div2_b", tbl[3], 2);
    div2 = 1'b0;
    check("div2 min pixel spacing", min_gap, 2);

    // Reset at pixel (10,6): remaining 6 lines form the partial first frame.
    pix_chk = 1'b1;
    run_frame(12, -1, 1'b0, 1, 6, 10);
    check("rstframe width", width, 20);
    check("rstframe height", height, 6);
    check("rstframe locked", locked, 0);
`ifdef LCD_RX_STATS_EN
    check("rstframe frame_count", frame_count, 1);
`endif
    frame_test("post_rst0", tbl[0], 1);
    frame_test("post_rst1", tbl[0], 1);
    frame_test("post_rst2", tbl[3], 1);

    // Over-long line: x and width saturate at 2047, and the width change drops lock.
    s0 = serr_cnt;
    p0 = pix_bad;
    pix_chk = 1'b1;
    for (int c = 0; c < 2056; c++) begin
      bit            de;
      logic [DW-1:0] d;
      de = (c < 2050);
      d  = de ? DW'($urandom) : '0;
      step(1'b1, de, 1'b1, 1'b1, d, (c > 2047) ? 2047 : c, 0);
    end
    check("sat width", width, 2047);
    check("sat last x", last_x, 2047);
    check("sat last y", last_y, 0);
    check("sat sync_error pulses", serr_cnt - s0, 1);
    check("sat locked", locked, 0);
    check("sat pixel stream errors", pix_bad - p0, 0);
`ifdef LCD_RX_STATS_EN
    check("end frame_count", frame_count, 4);
    check("end error_count", error_count, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
